// File: rtl/symbol_lock_ctrl.sv
// Symbol-lock sequencer for the 8b/10b receive path: acquires lock on K28.5 COMs,
// tracks clustered errors while locked, and forwards decoded symbols only while locked.
module symbol_lock_ctrl #(
    parameter int ACQ_COM_CNT = 4,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_RUN    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sym_valid,
    input  logic        dec_k,
    input  logic [7:0]  dec_data,
    input  logic        dec_err,
    input  logic        force_relock,
    output logic        sym_lock,
    output logic        lock_lost,
    output logic        rx_valid,
    output logic        rx_k,
    output logic [7:0]  rx_data,
    output logic        rx_err,
    output logic [1:0]  lock_state,
    output logic [15:0] err_total
);

    localparam int COM_W  = $clog2(ACQ_COM_CNT + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int GOOD_W = $clog2(GOOD_RUN + 1);

    localparam logic [COM_W-1:0]  COM_TARGET  = COM_W'(ACQ_COM_CNT);
    localparam logic [ERR_W-1:0]  ERR_TARGET  = ERR_W'(ERR_LIMIT);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(GOOD_RUN);

    typedef enum logic [1:0] {
        ST_LOS    = 2'b00,
        ST_ACQ    = 2'b01,
        ST_LOCKED = 2'b10,
        ST_ERRCHK = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [COM_W-1:0]   com_cnt_q, com_cnt_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic               sym_lock_q, sym_lock_d;
    logic               lock_lost_q, lock_lost_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_k_q, rx_k_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_err_q, rx_err_d;
    logic [15:0]        err_total_q, err_total_d;

    logic is_com;
    logic locked_now;

    assign is_com     = dec_k && (dec_data == 8'hBC) && !dec_err;
    assign locked_now = (state_q == ST_LOCKED) || (state_q == ST_ERRCHK);

    always_comb begin
        state_d     = state_q;
        com_cnt_d   = com_cnt_q;
        err_cnt_d   = err_cnt_q;
        good_cnt_d  = good_cnt_q;
        lock_lost_d = 1'b0;
        err_total_d = err_total_q;
        rx_valid_d  = sym_valid && locked_now;
        rx_k_d      = rx_k_q;
        rx_data_d   = rx_data_q;
        rx_err_d    = rx_err_q;

        if (sym_valid) begin
            rx_k_d    = dec_k;
            rx_data_d = dec_data;
            rx_err_d  = dec_err;
        end

        if (sym_valid && dec_err && locked_now && (err_total_q != 16'hFFFF)) begin
            err_total_d = err_total_q + 16'd1;
        end

        // A relock request wins over whatever the accepted symbol would have done.
        if (force_relock) begin
            state_d    = ST_LOS;
            com_cnt_d  = '0;
            err_cnt_d  = '0;
            good_cnt_d = '0;
        end else if (sym_valid) begin
            case (state_q)
                ST_LOS: begin
                    if (is_com) begin
                        state_d   = ST_ACQ;
                        com_cnt_d = COM_W'(1);
                    end
                end
                ST_ACQ: begin
                    if (dec_err) begin
                        state_d   = ST_LOS;
                        com_cnt_d = '0;
                    end else if (is_com) begin
                        if (com_cnt_q + COM_W'(1) == COM_TARGET) begin
                            state_d   = ST_LOCKED;
                            com_cnt_d = '0;
                        end else begin
                            com_cnt_d = com_cnt_q + COM_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (dec_err) begin
                        state_d    = ST_ERRCHK;
                        err_cnt_d  = ERR_W'(1);
                        good_cnt_d = '0;
                    end
                end
                ST_ERRCHK: begin
                    if (dec_err) begin
                        good_cnt_d = '0;
                        if (err_cnt_q + ERR_W'(1) == ERR_TARGET) begin
                            state_d     = ST_LOS;
                            err_cnt_d   = '0;
                            com_cnt_d   = '0;
                            lock_lost_d = 1'b1;
                        end else begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end else if (good_cnt_q + GOOD_W'(1) == GOOD_TARGET) begin
                        // A full good run retires one outstanding error.
                        good_cnt_d = '0;
                        err_cnt_d  = err_cnt_q - ERR_W'(1);
                        if (err_cnt_q == ERR_W'(1)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end
                end
                default: state_d = ST_LOS;
            endcase
        end

        sym_lock_d = (state_d == ST_LOCKED) || (state_d == ST_ERRCHK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOS;
            com_cnt_q   <= '0;
            err_cnt_q   <= '0;
            good_cnt_q  <= '0;
            sym_lock_q  <= 1'b0;
            lock_lost_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_k_q      <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_err_q    <= 1'b0;
            err_total_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            com_cnt_q   <= com_cnt_d;
            err_cnt_q   <= err_cnt_d;
            good_cnt_q  <= good_cnt_d;
            sym_lock_q  <= sym_lock_d;
            lock_lost_q <= lock_lost_d;
            rx_valid_q  <= rx_valid_d;
            rx_k_q      <= rx_k_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
            err_total_q <= err_total_d;
        end
    end

    assign sym_lock   = sym_lock_q;
    assign lock_lost  = lock_lost_q;
    assign rx_valid   = rx_valid_q;
    assign rx_k       = rx_k_q;
    assign rx_data    = rx_data_q;
    assign rx_err     = rx_err_q;
    assign lock_state = state_q;
    assign err_total  = err_total_q;

endmodule

// File: tb/tb_symbol_lock_ctrl.sv
// Self-checking bench for symbol_lock_ctrl: directed symbol streams, a behavioural
// lock model compared every cycle, plus literal checkpoints from the test scenarios.
module tb_symbol_lock_ctrl;

    logic        clk;
    logic        rst;
    logic        sym_valid;
    logic        dec_k;
    logic [7:0]  dec_data;
    logic        dec_err;
    logic        force_relock;
    logic        sym_lock;
    logic        lock_lost;
    logic        rx_valid;
    logic        rx_k;
    logic [7:0]  rx_data;
    logic        rx_err;
    logic [1:0]  lock_state;
    logic [15:0] err_total;

    int vec_count  = 0;
    int miscompare = 0;

    // Model state: lock flag, COMs seen while acquiring, outstanding errors, good streak.
    bit          m_locked;
    int          m_coms;
    int          m_errs;
    int          m_good;
    logic        exp_lock_lost;
    logic        exp_rx_valid;
    logic        exp_rx_k;
    logic [7:0]  exp_rx_data;
    logic        exp_rx_err;
    logic [15:0] exp_total;

    symbol_lock_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sym_valid    (sym_valid),
        .dec_k        (dec_k),
        .dec_data     (dec_data),
        .dec_err      (dec_err),
        .force_relock (force_relock),
        .sym_lock     (sym_lock),
        .lock_lost    (lock_lost),
        .rx_valid     (rx_valid),
        .rx_k         (rx_k),
        .rx_data      (rx_data),
        .rx_err       (rx_err),
        .lock_state   (lock_state),
        .err_total    (err_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] modelStateCode();
        if (m_locked) return (m_errs > 0) ? 2'b11 : 2'b10;
        return (m_coms > 0) ? 2'b01 : 2'b00;
    endfunction

    task automatic resetModel();
        m_locked      = 1'b0;
        m_coms        = 0;
        m_errs        = 0;
        m_good        = 0;
        exp_lock_lost = 1'b0;
        exp_rx_valid  = 1'b0;
        exp_rx_k      = 1'b0;
        exp_rx_data   = 8'h00;
        exp_rx_err    = 1'b0;
        exp_total     = 16'h0000;
    endtask

    task automatic modelStep(input logic v, input logic k, input logic [7:0] d,
                             input logic e, input logic fr);
        bit com;
        com           = k && (d == 8'hBC) && !e;
        exp_lock_lost = 1'b0;
        exp_rx_valid  = v && m_locked;
        if (v) begin
            exp_rx_k    = k;
            exp_rx_data = d;
            exp_rx_err  = e;
        end
        if (v && e && m_locked && exp_total != 16'hFFFF) exp_total = exp_total + 16'd1;
        if (fr) begin
            m_locked = 1'b0;
            m_coms   = 0;
            m_errs   = 0;
            m_good   = 0;
        end else if (v) begin
            if (!m_locked) begin
                if (e) m_coms = 0;
                else if (com) begin
                    m_coms = m_coms + 1;
                    if (m_coms == 4) begin
                        m_locked = 1'b1;
                        m_coms   = 0;
                    end
                end
            end else if (e) begin
                m_errs = m_errs + 1;
                m_good = 0;
                if (m_errs == 4) begin
                    m_locked      = 1'b0;
                    m_errs        = 0;
                    exp_lock_lost = 1'b1;
                end
            end else if (m_errs > 0) begin
                m_good = m_good + 1;
                if (m_good == 16) begin
                    m_good = 0;
                    m_errs = m_errs - 1;
                end
            end
        end
    endtask

    task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompare++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        vec_count++;
        checkField("sym_lock",   16'(sym_lock),   16'(m_locked));
        checkField("lock_lost",  16'(lock_lost),  16'(exp_lock_lost));
        checkField("rx_valid",   16'(rx_valid),   16'(exp_rx_valid));
        checkField("rx_k",       16'(rx_k),       16'(exp_rx_k));
        checkField("rx_data",    16'(rx_data),    16'(exp_rx_data));
        checkField("rx_err",     16'(rx_err),     16'(exp_rx_err));
        checkField("lock_state", 16'(lock_state), 16'(modelStateCode()));
        checkField("err_total",  err_total,       exp_total);
    endtask

    task automatic expectLit(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_count++;
        checkField(name, act, exp);
    endtask

    // Compare process: DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    task automatic applyStimulus(input logic v, input logic k, input logic [7:0] d,
                                 input logic e, input logic fr);
        @(negedge clk);
        sym_valid    = v;
        dec_k        = k;
        dec_data     = d;
        dec_err      = e;
        force_relock = fr;
        @(posedge clk);
        modelStep(v, k, d, e, fr);
        #1;
    endtask

    task automatic sendCom();
        applyStimulus(1'b1, 1'b1, 8'hBC, 1'b0, 1'b0);
    endtask

    task automatic sendData(input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic sendErr();
        applyStimulus(1'b1, 1'b0, 8'hE7, 1'b1, 1'b0);
    endtask

    task automatic sendIdle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pulseReset();
        #2;
        rst          = 1'b1;
        sym_valid    = 1'b0;
        force_relock = 1'b0;
        resetModel();
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        sym_valid    = 1'b0;
        dec_k        = 1'b0;
        dec_data     = 8'h00;
        dec_err      = 1'b0;
        force_relock = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sendIdle();

        // T2: acquisition with a data symbol between COMs, then forwarding
        sendCom();
        sendData(8'h4A);
        sendCom();
        sendCom();
        expectLit("t2_acq_state", 16'(lock_state), 16'h1);
        expectLit("t2_not_locked", 16'(sym_lock), 16'h0);
        sendCom();
        expectLit("t2_sym_lock", 16'(sym_lock), 16'h1);
        expectLit("t2_com_not_fwd", 16'(rx_valid), 16'h0);
        sendData(8'h4A);
        expectLit("t2_rx_valid", 16'(rx_valid), 16'h1);
        expectLit("t2_rx_data", 16'(rx_data), 16'h4A);
        expectLit("t2_rx_k", 16'(rx_k), 16'h0);

        // T1: asynchronous reset mid-stream clears every output at once
        pulseReset_check();

        // T3: an error during acquisition restarts the COM count
        sendCom();
        expectLit("t3_state_acq1", 16'(lock_state), 16'h1);
        sendCom();
        sendErr();
        expectLit("t3_state_los", 16'(lock_state), 16'h0);
        sendCom();
        expectLit("t3_state_acq2", 16'(lock_state), 16'h1);
        sendCom();
        sendCom();
        expectLit("t3_still_acq", 16'(lock_state), 16'h1);
        sendCom();
        expectLit("t3_state_locked", 16'(lock_state), 16'h2);

        // T4: four errors, each separated by three good symbols, drop lock
        for (int i = 0; i < 4; i++) begin
            sendErr();
            if (i == 0) expectLit("t4_errchk", 16'(lock_state), 16'h3);
            if (i < 3) for (int j = 0; j < 3; j++) sendData(8'(8'h10 + j));
        end
        expectLit("t4_lock_lost", 16'(lock_lost), 16'h1);
        expectLit("t4_sym_lock", 16'(sym_lock), 16'h0);
        expectLit("t4_err_total", err_total, 16'd4);
        expectLit("t4_err_fwd", 16'(rx_err), 16'h1);
        sendIdle();
        expectLit("t4_lost_pulse", 16'(lock_lost), 16'h0);

        // T5: a full good run retires an error; a short run does not
        repeat (4) sendCom();
        sendErr();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expectLit("t5_before_16th", 16'(lock_state), 16'h3);
            sendData(8'(i));
        end
        expectLit("t5_relocked", 16'(lock_state), 16'h2);
        sendErr();
        repeat (15) sendData(8'h55);
        sendErr();
        expectLit("t5_two_errs", 16'(lock_state), 16'h3);
        expectLit("t5_err_total", err_total, 16'd7);
        repeat (16) sendData(8'h66);
        expectLit("t5_one_left", 16'(lock_state), 16'h3);
        repeat (16) sendData(8'h77);
        expectLit("t5_clean", 16'(lock_state), 16'h2);

        // T6: sym_valid toggling, then force_relock
        sendData(8'h11);
        expectLit("t6_valid_on", 16'(rx_valid), 16'h1);
        sendIdle();
        expectLit("t6_valid_off", 16'(rx_valid), 16'h0);
        expectLit("t6_data_hold", 16'(rx_data), 16'h11);
        expectLit("t6_state_hold", 16'(lock_state), 16'h2);
        sendData(8'h22);
        sendIdle();
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        expectLit("t6_relock_state", 16'(lock_state), 16'h0);
        expectLit("t6_relock_nolost", 16'(lock_lost), 16'h0);
        expectLit("t6_relock_fwd", 16'(rx_data), 16'h33);
        sendCom();
        applyStimulus(1'b1, 1'b1, 8'hBC, 1'b0, 1'b1);
        expectLit("t6_relock_acq", 16'(lock_state), 16'h0);
        repeat (3) sendIdle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

    task automatic pulseReset_check();
        #2;
        rst          = 1'b1;
        sym_valid    = 1'b0;
        force_relock = 1'b0;
        resetModel();
        #1;
        expectLit("t1_sym_lock", 16'(sym_lock), 16'h0);
        expectLit("t1_rx_valid", 16'(rx_valid), 16'h0);
        expectLit("t1_rx_data", 16'(rx_data), 16'h0);
        expectLit("t1_lock_state", 16'(lock_state), 16'h0);
        expectLit("t1_err_total", err_total, 16'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

endmodule
